// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter paced by a 16x
// oversample strobe, with optional parity and one or two stop bits.
module uart_tx #(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tx,
    input  logic [7:0] data_in,
    input  logic       wr,
    output logic       ready,
    output logic       txd,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] shreg;
    logic [7:0] shreg_n;
    logic [3:0] tick;
    logic [3:0] tick_n;
    logic [2:0] bitn;
    logic [2:0] bitn_n;
    logic       stopn;
    logic       stopn_n;
    logic       par;
    logic       par_n;
    logic       txd_n;
    logic       done_n;
    logic       bit_end;
    logic       last_stop;

    assign ready     = (state == IDLE);
    assign bit_end   = en_tx && (tick == 4'd15);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stopn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= 8'h00;
            tick    <= 4'd0;
            bitn    <= 3'd0;
            stopn   <= 1'b0;
            par     <= 1'b0;
            txd     <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            tick    <= tick_n;
            bitn    <= bitn_n;
            stopn   <= stopn_n;
            par     <= par_n;
            txd     <= txd_n;
            tx_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        tick_n  = tick;
        bitn_n  = bitn;
        stopn_n = stopn;
        par_n   = par;
        txd_n   = txd;
        done_n  = 1'b0;

        // tick runs free inside a frame; bit_end marks its 15->0 wrap
        if (state inside {START, DATA, PARITY, STOP} && en_tx) begin
            tick_n = tick + 4'd1;
        end

        unique case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (wr) begin
                    shreg_n = data_in;
                    par_n   = PARITY_ODD;
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (en_tx) begin
                    txd_n   = 1'b0;
                    tick_n  = 4'd0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_n   = shreg[0];
                    par_n   = par ^ shreg[0];
                    bitn_n  = 3'd0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bitn != 3'd7) begin
                        txd_n  = shreg[1];
                        par_n  = par ^ shreg[1];
                        bitn_n = bitn + 3'd1;
                    end else if (PARITY_EN) begin
                        txd_n   = par;
                        state_n = PARITY;
                    end else begin
                        txd_n   = 1'b1;
                        stopn_n = 1'b0;
                        state_n = STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    txd_n   = 1'b1;
                    stopn_n = 1'b0;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!last_stop) begin
                        stopn_n = 1'b1;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART, directly downstream of the baud divisor. Consumes the divisor's `en_tx` strobe (one `clk`-wide pulse per 1/16 bit period) and shifts a parallel byte out on `txd` as an 8-bit asynchronous frame: start bit, data LSB-first, optional parity, and 1 or 2 stop bits. A valid/ready handshake accepts one byte per frame from the bus-side register file.

## Interface
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 and 2.
- `clk`, input, 1: UART clock, the same clock that drives the divisor.
- `rst`, input, 1: asynchronous, active-low reset.
- `en_tx`, input, 1: oversample strobe from the divisor. 16 strobes make one bit period.
- `data_in`, input, 8: byte to send. Sampled only on acceptance.
- `wr`, input, 1: write request, valid.
- `ready`, output, 1: block can accept a byte. Equals (state==IDLE).
- `txd`, output, 1: serial line, registered. Idles high.
- `tx_done`, output, 1: one-`clk` pulse when the last stop bit completes.

## Operation
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- Registers:
  - `shreg[7:0]`
  - `tick[3:0]`: counts `en_tx` strobes within a bit
  - `bitn[2:0]`: data bit index
  - `stopn`: stop bit index
  - `par`: running parity
- IDLE:
  - `txd`=1 and `ready`=1.
  - If `wr` is high at a `clk` edge: `shreg`<=`data_in`, `par`<=`PARITY_ODD`, go to SYNC.
- SYNC:
  - `txd` stays 1. The block waits for the next `en_tx`.
  - On that strobe: `txd`<=0, `tick`<=0, go to START.
  - An `en_tx` in the same cycle as acceptance does not count.
- Bit timing, all of START, DATA, PARITY and STOP:
  - Each `en_tx` increments `tick`, which wraps 15→0.
  - The strobe that arrives with `tick`==15 ends the bit. The next bit value is driven on that same edge.
  - Every bit therefore lasts exactly 16 `en_tx` periods.
- START: at the end of the bit, `txd`<=`shreg[0]`, `par`^=`shreg[0]`, `bitn`<=0, go to DATA.
- DATA:
  - At each bit end, `shreg` shifts right by one.
  - If `bitn`<7: `txd`<=next bit, `par` updates, `bitn`++.
  - If `bitn`==7: go to PARITY with `txd`<=`par` when `PARITY_EN`=1, otherwise go to STOP with `txd`<=1.
- PARITY: at the end of the bit, `txd`<=1, `stopn`<=0, go to STOP.
- STOP:
  - At a bit end with `stopn`<`STOP_BITS`-1: `stopn`++ and stay in STOP.
  - At the last bit end: go to IDLE and pulse `tx_done`=1 for that one cycle. `txd` stays 1.
- `wr` while `ready`=0 is ignored. No byte is captured, and changes on `data_in` have no effect on the frame in flight.
- `en_tx` held high every cycle is legal. One bit then lasts 16 `clk`.
- Reset asserted at any time forces `txd`=1 immediately, with no glitch low. A partially sent frame is abandoned.

## Timing
- Reset values:
  - state IDLE, so `ready`=1
  - `txd`=1
  - `tx_done`=0
  - `tick`, `bitn`, `stopn`, `par` and `shreg` all 0
- `ready` is combinational from state. It falls in the cycle after the `wr` acceptance edge.
- Start latency: `txd` falls on the edge of the first `en_tx` that is strictly after acceptance. With `en_tx` period P, this is between 1 and P `clk` after acceptance.
- Frame length from the falling start edge to `tx_done`: (10 + `PARITY_EN` + `STOP_BITS` − 1) × 16 × P `clk`.
- `tx_done` and `ready`=1 appear in the same cycle.
- Back-to-back: the next byte can be accepted in the first IDLE cycle, one cycle after the final stop tick. There is no extra idle bit beyond the stop bits and the SYNC wait.

## Test plan
- Reset, then idle for 100 `clk` with `en_tx` every 4 `clk` → `txd`=1, `ready`=1, `tx_done`=0 throughout.
- Send 0x55 with `PARITY_EN`=0 and `STOP_BITS`=1, `en_tx` every 4 `clk` → `txd` shows 0,1,0,1,0,1,0,1,0,1, each bit exactly 64 `clk`. `tx_done` pulses once, 640 `clk` after the start edge. `ready` is back high in the same cycle.
- `PARITY_EN`=1, `PARITY_ODD`=0, byte 0x07 → parity bit = 1. `PARITY_ODD`=1, byte 0x00 → parity bit = 1. `STOP_BITS`=2 → line held high for 128 `clk` before `tx_done`.
- Back-to-back: raise `wr` with 0xA3 in the `tx_done` cycle, then hold `wr` with 0xFF while busy → 0xA3 frame follows immediately with bits 1,1,0,0,0,1,0,1. 0xFF is only sent if `wr` is still high when `ready` returns.
- Reset pulse in the middle of data bit 4 → `txd`=1 asynchronously and `ready`=1. After release, a new 0x0F frame is sent complete and correct.
- `en_tx` tied high, 0x80 → each bit lasts 16 `clk`. `wr` coincident with `en_tx` → start edge falls on the next cycle.
